bullet_table: RTL and testbench

Parametrised bullet object table for the playfield renderer. It holds DEPTH bullet records and accepts spawns through a valid/ready handshake, with lowest-free-slot allocation. On every frame tick it runs a sequential motion sweep that advances each live bullet by its velocity and retires any bullet that leaves the field. Two independent combinational read ports feed the sprite renderer.

---
 rtl/bullet_table.sv | 245 ++++++++++++++++++++++++
 tb/tb_bullet_table.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_table.sv
// bullet_table: object table for on-screen bullets.
//
// Holds DEPTH bullet records (position, size, velocity, colour, active bit).
// - Spawn: valid/ready handshake. The bullet goes into the lowest-index free slot.
// - Kill: retires one slot. It is accepted in any state.
// - Motion sweep: on frame_tick, visits slots 0..DEPTH-1, one slot per cycle. Each
//   live bullet moves by its velocity. A bullet that would leave the field is retired.
// - Read ports: two independent combinational ports for the sprite renderer.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   frame_tick                      starts a sweep when the table is idle
//   spawn_valid/spawn_ready         spawn handshake
//   spawn_x/y/w/h/vx/vy/color       fields of the new bullet
//   spawn_idx                       slot the next accepted spawn goes into
//   kill_valid, kill_idx            retire request
//   rd_idx1/2                       read selects
//   pos_x*/pos_y*/size_w*/size_h*   read-port fields
//   color*, is_render*              read-port colour and live flag
//   busy, sweep_done, tick_overrun  sweep status
//   active_count                    registered count of live slots
module bullet_table #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned COORD_W = 8,
  parameter int unsigned VEL_W   = 4,
  parameter int unsigned COLOR_W = 3,
  parameter int unsigned X_MAX   = 255,
  parameter int unsigned Y_MAX   = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               spawn_valid,
  output logic               spawn_ready,
  input  logic [COORD_W-1:0] spawn_x,
  input  logic [COORD_W-1:0] spawn_y,
  input  logic [COORD_W-1:0] spawn_w,
  input  logic [COORD_W-1:0] spawn_h,
  input  logic [VEL_W-1:0]   spawn_vx,
  input  logic [VEL_W-1:0]   spawn_vy,
  input  logic [COLOR_W-1:0] spawn_color,
  output logic [IDX_W-1:0]   spawn_idx,
  input  logic               kill_valid,
  input  logic [IDX_W-1:0]   kill_idx,
  input  logic [IDX_W-1:0]   rd_idx1,
  input  logic [IDX_W-1:0]   rd_idx2,
  output logic [COORD_W-1:0] pos_x1,
  output logic [COORD_W-1:0] pos_y1,
  output logic [COORD_W-1:0] size_w1,
  output logic [COORD_W-1:0] size_h1,
  output logic [COLOR_W-1:0] color1,
  output logic               is_render1,
  output logic [COORD_W-1:0] pos_x2,
  output logic [COORD_W-1:0] pos_y2,
  output logic [COORD_W-1:0] size_w2,
  output logic [COORD_W-1:0] size_h2,
  output logic [COLOR_W-1:0] color2,
  output logic               is_render2,
  output logic               busy,
  output logic               sweep_done,
  output logic               tick_overrun,
  output logic [IDX_W:0]     active_count
);

  localparam int unsigned SumW  = COORD_W + 2;
  localparam int unsigned IdxW1 = IDX_W + 1;
  localparam logic [SumW-1:0]  XMaxW   = SumW'(X_MAX);
  localparam logic [SumW-1:0]  YMaxW   = SumW'(Y_MAX);
  localparam logic [IDX_W-1:0] LastPtr = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W:0]   DepthW  = IdxW1'(DEPTH);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W:0]   count_q, count_d;

  logic [DEPTH-1:0]   active_q, active_d;
  logic [COORD_W-1:0] x_q [DEPTH];
  logic [COORD_W-1:0] x_d [DEPTH];
  logic [COORD_W-1:0] y_q [DEPTH];
  logic [COORD_W-1:0] y_d [DEPTH];
  logic [COORD_W-1:0] w_q [DEPTH];
  logic [COORD_W-1:0] w_d [DEPTH];
  logic [COORD_W-1:0] h_q [DEPTH];
  logic [COORD_W-1:0] h_d [DEPTH];
  logic [VEL_W-1:0]   vx_q [DEPTH];
  logic [VEL_W-1:0]   vx_d [DEPTH];
  logic [VEL_W-1:0]   vy_q [DEPTH];
  logic [VEL_W-1:0]   vy_d [DEPTH];
  logic [COLOR_W-1:0] col_q [DEPTH];
  logic [COLOR_W-1:0] col_d [DEPTH];

  logic [IDX_W-1:0] free_idx;
  logic             any_free;
  logic [SumW-1:0]  nx, ny;
  logic             off_field;

  // Status outputs
  assign busy         = (state_q == StSweep);
  assign sweep_done   = busy && (ptr_q == LastPtr);
  assign tick_overrun = busy && frame_tick;
  assign active_count = count_q;

  // Lowest-index free slot. Reads 0 when the table is full.
  always_comb begin
    free_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!active_q[i]) free_idx = IDX_W'(i);
    end
  end

  assign any_free    = ~&active_q;
  assign spawn_ready = (state_q == StIdle) && !reset && any_free;
  assign spawn_idx   = free_idx;

  // Candidate position of the slot under the sweep pointer.
  // Two guard bits catch both underflow (sign bit set) and overflow past the maximum.
  always_comb begin
    nx = {2'b00, x_q[ptr_q]} + {{(SumW - VEL_W){vx_q[ptr_q][VEL_W-1]}}, vx_q[ptr_q]};
    ny = {2'b00, y_q[ptr_q]} + {{(SumW - VEL_W){vy_q[ptr_q][VEL_W-1]}}, vy_q[ptr_q]};
    off_field = nx[SumW-1] || (nx > XMaxW) || ny[SumW-1] || (ny > YMaxW);
  end

  // Sweep FSM
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (frame_tick) begin
          state_d = StSweep;
          ptr_d   = '0;
        end
      end
      StSweep: begin
        if (ptr_q == LastPtr) state_d = StIdle;
        else                  ptr_d   = ptr_q + IDX_W'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  // Table next state. The kill is applied last, so it overrides the sweep.
  // It only acts on slots that were live before the edge, so it never cancels
  // a spawn that lands in the same cycle.
  always_comb begin
    active_d = active_q;
    x_d      = x_q;
    y_d      = y_q;
    w_d      = w_q;
    h_d      = h_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    col_d    = col_q;

    if (busy && active_q[ptr_q]) begin
      if (off_field) begin
        active_d[ptr_q] = 1'b0;
      end else begin
        x_d[ptr_q] = nx[COORD_W-1:0];
        y_d[ptr_q] = ny[COORD_W-1:0];
      end
    end

    if (spawn_valid && spawn_ready) begin
      x_d[free_idx]      = spawn_x;
      y_d[free_idx]      = spawn_y;
      w_d[free_idx]      = spawn_w;
      h_d[free_idx]      = spawn_h;
      vx_d[free_idx]     = spawn_vx;
      vy_d[free_idx]     = spawn_vy;
      col_d[free_idx]    = spawn_color;
      active_d[free_idx] = 1'b1;
    end

    if (kill_valid && ({1'b0, kill_idx} < DepthW) && active_q[kill_idx]) begin
      active_d[kill_idx] = 1'b0;
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      count_d = count_d + IdxW1'(active_q[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      count_q  <= '0;
      active_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        x_q[i]   <= '0;
        y_q[i]   <= '0;
        w_q[i]   <= '0;
        h_q[i]   <= '0;
        vx_q[i]  <= '0;
        vy_q[i]  <= '0;
        col_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
      w_q      <= w_d;
      h_q      <= h_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      col_q    <= col_d;
    end
  end

  // Read ports. An out-of-range index returns all-zero fields.
  always_comb begin
    pos_x1 = '0; pos_y1 = '0; size_w1 = '0; size_h1 = '0; color1 = '0; is_render1 = 1'b0;
    if ({1'b0, rd_idx1} < DepthW) begin
      pos_x1     = x_q[rd_idx1];
      pos_y1     = y_q[rd_idx1];
      size_w1    = w_q[rd_idx1];
      size_h1    = h_q[rd_idx1];
      color1     = col_q[rd_idx1];
      is_render1 = active_q[rd_idx1];
    end
  end

  always_comb begin
    pos_x2 = '0; pos_y2 = '0; size_w2 = '0; size_h2 = '0; color2 = '0; is_render2 = 1'b0;
    if ({1'b0, rd_idx2} < DepthW) begin
      pos_x2     = x_q[rd_idx2];
      pos_y2     = y_q[rd_idx2];
      size_w2    = w_q[rd_idx2];
      size_h2    = h_q[rd_idx2];
      color2     = col_q[rd_idx2];
      is_render2 = active_q[rd_idx2];
    end
  end

endmodule

// File: tb/tb_bullet_table.sv
// Self-checking bench for bullet_table (default parameters).
// Every cycle, the bench compares all outputs against a behavioural table model.
// A constant vector table checks motion and retirement at the field edges.
// Hand-written sequences cover fill/kill, overrun, kill-during-sweep and reset
// mid-sweep. A randomized run finishes the test.
module tb_bullet_table;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick, spawn_valid, spawn_ready, kill_valid;
  logic [7:0] spawn_x, spawn_y, spawn_w, spawn_h;
  logic [3:0] spawn_vx, spawn_vy;
  logic [2:0] spawn_color, spawn_idx, kill_idx, rd_idx1, rd_idx2;
  logic [7:0] pos_x1, pos_y1, size_w1, size_h1, pos_x2, pos_y2, size_w2, size_h2;
  logic [2:0] color1, color2;
  logic       is_render1, is_render2, busy, sweep_done, tick_overrun;
  logic [3:0] active_count;

  bullet_table dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_w(spawn_w), .spawn_h(spawn_h),
    .spawn_vx(spawn_vx), .spawn_vy(spawn_vy), .spawn_color(spawn_color),
    .spawn_idx(spawn_idx), .kill_valid(kill_valid), .kill_idx(kill_idx),
    .rd_idx1(rd_idx1), .rd_idx2(rd_idx2),
    .pos_x1(pos_x1), .pos_y1(pos_y1), .size_w1(size_w1), .size_h1(size_h1),
    .color1(color1), .is_render1(is_render1),
    .pos_x2(pos_x2), .pos_y2(pos_y2), .size_w2(size_w2), .size_h2(size_h2),
    .color2(color2), .is_render2(is_render2),
    .busy(busy), .sweep_done(sweep_done), .tick_overrun(tick_overrun),
    .active_count(active_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- Behavioural model ----------------
  int mx[8], my[8], mw[8], mh[8], mvx[8], mvy[8], mc[8];
  bit mact[8];
  bit mbusy;
  int mptr, mcount;
  bit s_busy, s_done, s_ovr;

  function automatic int lowest_free();
    for (int i = 0; i < 8; i++) if (!mact[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mx[i] = 0; my[i] = 0; mw[i] = 0; mh[i] = 0;
      mvx[i] = 0; mvy[i] = 0; mc[i] = 0; mact[i] = 0;
    end
    mbusy = 0; mptr = 0; mcount = 0;
  endtask

  task automatic model_step();
    bit old[8];
    int low, nx, ny, cnt;
    old = mact;
    low = lowest_free();
    if (mbusy && old[mptr]) begin
      nx = mx[mptr] + mvx[mptr];
      ny = my[mptr] + mvy[mptr];
      if (nx < 0 || nx > 255 || ny < 0 || ny > 255) mact[mptr] = 0;
      else begin mx[mptr] = nx; my[mptr] = ny; end
    end
    if (spawn_valid && !mbusy && low >= 0) begin
      mx[low] = spawn_x; my[low] = spawn_y; mw[low] = spawn_w; mh[low] = spawn_h;
      mvx[low] = int'($signed(spawn_vx)); mvy[low] = int'($signed(spawn_vy));
      mc[low] = spawn_color; mact[low] = 1;
    end
    if (kill_valid && old[kill_idx]) mact[kill_idx] = 0;
    cnt = 0;
    for (int i = 0; i < 8; i++) cnt += int'(old[i]);
    mcount = cnt;
    if (mbusy) begin
      if (mptr == 7) mbusy = 0;
      else mptr++;
    end else if (frame_tick) begin
      mbusy = 1; mptr = 0;
    end
  endtask

  task automatic check_outputs();
    int low, r1, r2;
    low = lowest_free();
    chk("spawn_ready", int'(spawn_ready), int'(!reset && !mbusy && low >= 0));
    chk("spawn_idx", int'(spawn_idx), (low < 0) ? 0 : low);
    chk("busy", int'(busy), int'(mbusy));
    chk("sweep_done", int'(sweep_done), int'(mbusy && mptr == 7));
    chk("tick_overrun", int'(tick_overrun), int'(mbusy && frame_tick));
    chk("active_count", int'(active_count), mcount);
    r1 = int'(rd_idx1); r2 = int'(rd_idx2);
    chk("pos_x1", int'(pos_x1), mx[r1]);   chk("pos_y1", int'(pos_y1), my[r1]);
    chk("size_w1", int'(size_w1), mw[r1]); chk("size_h1", int'(size_h1), mh[r1]);
    chk("color1", int'(color1), mc[r1]);   chk("is_render1", int'(is_render1), int'(mact[r1]));
    chk("pos_x2", int'(pos_x2), mx[r2]);   chk("pos_y2", int'(pos_y2), my[r2]);
    chk("size_w2", int'(size_w2), mw[r2]); chk("size_h2", int'(size_h2), mh[r2]);
    chk("color2", int'(color2), mc[r2]);   chk("is_render2", int'(is_render2), int'(mact[r2]));
    s_busy = busy; s_done = sweep_done; s_ovr = tick_overrun;
  endtask

  // Inputs are driven at posedge+1; the cycle checks at +2 and then advances one edge.
  task automatic cycle();
    #1;
    if (reset) model_reset();
    check_outputs();
    if (!reset) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    frame_tick = 0; spawn_valid = 0; kill_valid = 0; kill_idx = 0;
  endtask

  task automatic set_spawn_safe();
    spawn_x = 8'($urandom_range(20, 200)); spawn_y = 8'($urandom_range(20, 200));
    spawn_w = 8'($urandom); spawn_h = 8'($urandom);
    spawn_vx = 4'($urandom); spawn_vy = 4'($urandom); spawn_color = 3'($urandom);
  endtask

  // Tick, then run 12 cycles counting busy, done and overrun.
  // Optional second tick and kill at given busy-cycle numbers.
  task automatic sweep_run(input int tick_at, input int kill_at, input int kill_slot,
                           output int nb, output int nd, output int no);
    nb = 0; nd = 0; no = 0;
    idle_inputs();
    frame_tick = 1;
    cycle();
    for (int c = 0; c < 12; c++) begin
      frame_tick = (c == tick_at);
      kill_valid = (c == kill_at);
      kill_idx   = 3'(kill_slot);
      cycle();
      nb += int'(s_busy); nd += int'(s_done); no += int'(s_ovr);
    end
    idle_inputs();
  endtask

  typedef struct {
    logic [7:0] x, y, w, h;
    logic [3:0] vx, vy;
    logic [2:0] c;
    logic [7:0] ex, ey;
    logic       alive;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [7:0] edge_coord();
    int k;
    k = int'($urandom_range(0, 7));
    case (k)
      0: return 8'd0;
      1: return 8'd1;
      2: return 8'd254;
      3: return 8'd255;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int nb, nd, no;
    // x, y, w, h, vx, vy, colour -> x, y and live flag after one sweep
    tbl[0] = '{8'd10,  8'd20,  8'd4, 8'd4, 4'h2, 4'hF, 3'd5, 8'd12,  8'd19,  1'b1};
    tbl[1] = '{8'd254, 8'd100, 8'd2, 8'd2, 4'h3, 4'h0, 3'd1, 8'd254, 8'd100, 1'b0};
    tbl[2] = '{8'd50,  8'd0,   8'd3, 8'd3, 4'h0, 4'hF, 3'd2, 8'd50,  8'd0,   1'b0};
    tbl[3] = '{8'd255, 8'd255, 8'd1, 8'd1, 4'h0, 4'h0, 3'd3, 8'd255, 8'd255, 1'b1};
    tbl[4] = '{8'd250, 8'd7,   8'd5, 8'd5, 4'h5, 4'h7, 3'd4, 8'd255, 8'd14,  1'b1};
    tbl[5] = '{8'd1,   8'd248, 8'd6, 8'd6, 4'hF, 4'h7, 3'd6, 8'd0,   8'd255, 1'b1};
    tbl[6] = '{8'd0,   8'd30,  8'd7, 8'd7, 4'h8, 4'h0, 3'd7, 8'd0,   8'd30,  1'b0};
    tbl[7] = '{8'd100, 8'd250, 8'd8, 8'd8, 4'h8, 4'h6, 3'd0, 8'd100, 8'd250, 1'b0};

    reset = 1; idle_inputs(); rd_idx1 = 0; rd_idx2 = 0;
    spawn_x = 0; spawn_y = 0; spawn_w = 0; spawn_h = 0;
    spawn_vx = 0; spawn_vy = 0; spawn_color = 0;
    model_reset();
    #2;
    chk("rst_spawn_ready", int'(spawn_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_active_count", int'(active_count), 0);
    @(posedge clk); #1;
    cycle();
    reset = 0;
    cycle();

    // Table fill: slots are allocated in order 0..7
    for (int i = 0; i < 8; i++) begin
      spawn_x = tbl[i].x; spawn_y = tbl[i].y; spawn_w = tbl[i].w; spawn_h = tbl[i].h;
      spawn_vx = tbl[i].vx; spawn_vy = tbl[i].vy; spawn_color = tbl[i].c;
      spawn_valid = 1;
      #1 chk("tbl_spawn_idx", int'(spawn_idx), i);
      cycle();
    end
    spawn_valid = 0;
    cycle();
    chk("full_spawn_ready", int'(spawn_ready), 0);
    chk("full_active_count", int'(active_count), 8);
    for (int i = 0; i < 8; i++) begin
      rd_idx1 = 3'(i);
      #1;
      chk("tbl_pre_x", int'(pos_x1), int'(tbl[i].x));
      chk("tbl_pre_y", int'(pos_y1), int'(tbl[i].y));
      chk("tbl_pre_color", int'(color1), int'(tbl[i].c));
      cycle();
    end

    // One sweep over the table
    sweep_run(-1, -1, 0, nb, nd, no);
    chk("sweep_busy_cycles", nb, 8);
    chk("sweep_done_pulses", nd, 1);
    chk("sweep_overruns", no, 0);
    for (int i = 0; i < 8; i++) begin
      rd_idx1 = 3'(i); rd_idx2 = 3'(7 - i);
      #1;
      chk("tbl_x", int'(pos_x1), int'(tbl[i].ex));
      chk("tbl_y", int'(pos_y1), int'(tbl[i].ey));
      chk("tbl_w", int'(size_w1), int'(tbl[i].w));
      chk("tbl_alive", int'(is_render1), int'(tbl[i].alive));
      cycle();
    end
    chk("tbl_active_count", int'(active_count), 4);

    // Second tick three cycles into a sweep
    sweep_run(3, -1, 0, nb, nd, no);
    chk("ovr_busy_cycles", nb, 8);
    chk("ovr_pulses", no, 1);
    chk("ovr_done_pulses", nd, 1);

    // Fill with safe bullets, kill slot 3, then spawn and kill in the same cycle
    reset = 1; cycle(); reset = 0;
    for (int i = 0; i < 8; i++) begin
      set_spawn_safe(); spawn_valid = 1; cycle();
    end
    spawn_valid = 0;
    #1 chk("fill_ready_low", int'(spawn_ready), 0);
    kill_valid = 1; kill_idx = 3; cycle(); kill_valid = 0;
    #1 chk("kill_ready_high", int'(spawn_ready), 1);
    chk("kill_spawn_idx", int'(spawn_idx), 3);
    set_spawn_safe(); spawn_valid = 1; kill_valid = 1; kill_idx = 0;
    cycle();
    idle_inputs(); rd_idx1 = 0; rd_idx2 = 3;
    #1 chk("sk_spawn_idx", int'(spawn_idx), 0);
    chk("sk_killed_slot", int'(is_render1), 0);
    chk("sk_spawned_slot", int'(is_render2), 1);
    set_spawn_safe(); spawn_valid = 1; cycle(); spawn_valid = 0;

    // Kill on slot 5 in the cycle the sweep visits it
    sweep_run(-1, 5, 5, nb, nd, no);
    rd_idx1 = 5;
    #1 chk("kill_sweep_slot5", int'(is_render1), 0);
    chk("kill_sweep_busy", nb, 8);
    cycle();

    // Reset in the middle of a sweep
    frame_tick = 1; cycle(); frame_tick = 0; cycle(); cycle();
    reset = 1;
    #1 chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_count", int'(active_count), 0);
    chk("mid_rst_render", int'(is_render1), 0);
    cycle(); reset = 0;
    for (int i = 0; i < 8; i++) begin
      rd_idx1 = 3'(i);
      #1 chk("post_rst_render", int'(is_render1), 0);
      cycle();
    end

    // Randomized run against the model
    for (int n = 0; n < 1500; n++) begin
      reset       = ($urandom_range(0, 399) == 0);
      spawn_valid = ($urandom_range(0, 2) != 0);
      spawn_x = edge_coord(); spawn_y = edge_coord();
      spawn_w = 8'($urandom); spawn_h = 8'($urandom);
      spawn_vx = 4'($urandom); spawn_vy = 4'($urandom); spawn_color = 3'($urandom);
      kill_valid = ($urandom_range(0, 4) == 0);
      kill_idx   = 3'($urandom);
      frame_tick = ($urandom_range(0, 12) == 0);
      rd_idx1 = 3'($urandom); rd_idx2 = 3'($urandom);
      cycle();
    end
    reset = 0; idle_inputs();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
